// File: rtl/dilated_tap_buffer.sv
// Per-channel circular history buffer feeding a dilated conv1d layer.
// Each accepted activation vector is stored, and four taps spaced DILATION
// samples apart (newest to oldest) are presented on a registered output
// one cycle after the write, with the newest tap bypassed from the input.
module dilated_tap_buffer #(
    parameter int W        = 16,
    parameter int C        = 4,
    parameter int DILATION = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [W-1:0] inp [0:C-1],
    input  logic                inp_v,
    output logic signed [W-1:0] a0  [0:C-1],
    output logic signed [W-1:0] a1  [0:C-1],
    output logic signed [W-1:0] a2  [0:C-1],
    output logic signed [W-1:0] a3  [0:C-1],
    output logic                out_v,
    output logic                primed
);

    localparam int DEPTH = 3 * DILATION + 1;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);

    logic signed [W-1:0] mem_q [0:DEPTH-1][0:C-1];
    logic [PW-1:0]       wp_q, wp_d;
    logic [CW-1:0]       fill_q, fill_d;
    logic signed [W-1:0] a0_q [0:C-1];
    logic signed [W-1:0] a1_q [0:C-1];
    logic signed [W-1:0] a2_q [0:C-1];
    logic signed [W-1:0] a3_q [0:C-1];
    logic signed [W-1:0] a0_d [0:C-1];
    logic signed [W-1:0] a1_d [0:C-1];
    logic signed [W-1:0] a2_d [0:C-1];
    logic signed [W-1:0] a3_d [0:C-1];
    logic                out_v_q;

    // Index 'off' entries behind n, wrapped into 0..DEPTH-1. Since off is at
    // most 3*DILATION < DEPTH, one conditional subtract is a full wrap.
    function automatic logic [PW-1:0] back_idx(input logic [PW-1:0] n, input int off);
        int s;
        s = int'(n) + DEPTH - off;
        if (s >= DEPTH) begin
            s = s - DEPTH;
        end
        return PW'(s);
    endfunction

    // Next-state: advance pointer/fill and gather taps around the entry being
    // written. The older taps never alias the write slot, so reading the
    // current storage already gives post-write contents; the newest tap comes
    // straight from the input.
    always_comb begin
        wp_d   = wp_q;
        fill_d = fill_q;
        a0_d   = a0_q;
        a1_d   = a1_q;
        a2_d   = a2_q;
        a3_d   = a3_q;
        if (inp_v) begin
            wp_d   = (wp_q == PW'(DEPTH - 1)) ? '0 : wp_q + 1'b1;
            fill_d = (fill_q == CW'(DEPTH)) ? fill_q : fill_q + 1'b1;
            for (int c = 0; c < C; c++) begin
                a3_d[c] = inp[c];
                a2_d[c] = mem_q[back_idx(wp_q, DILATION)][c];
                a1_d[c] = mem_q[back_idx(wp_q, 2 * DILATION)][c];
                a0_d[c] = mem_q[back_idx(wp_q, 3 * DILATION)][c];
            end
        end
    end

    // Sample storage: cleared on reset so unwritten history reads as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int d = 0; d < DEPTH; d++) begin
                for (int c = 0; c < C; c++) begin
                    mem_q[d][c] <= '0;
                end
            end
        end else if (inp_v) begin
            for (int c = 0; c < C; c++) begin
                mem_q[wp_q][c] <= inp[c];
            end
        end
    end

    // Pointer, fill counter, tap registers and the update strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q    <= '0;
            fill_q  <= '0;
            out_v_q <= 1'b0;
            for (int c = 0; c < C; c++) begin
                a0_q[c] <= '0;
                a1_q[c] <= '0;
                a2_q[c] <= '0;
                a3_q[c] <= '0;
            end
        end else begin
            wp_q    <= wp_d;
            fill_q  <= fill_d;
            out_v_q <= inp_v;
            a0_q    <= a0_d;
            a1_q    <= a1_d;
            a2_q    <= a2_d;
            a3_q    <= a3_d;
        end
    end

    assign a0     = a0_q;
    assign a1     = a1_q;
    assign a2     = a2_q;
    assign a3     = a3_q;
    assign out_v  = out_v_q;
    assign primed = (fill_q == CW'(DEPTH));

endmodule

// File: tb/tb_dilated_tap_buffer.sv
// Self-checking bench for dilated_tap_buffer: a sample-history model feeds a
// scoreboard queue checked on every cycle, plus table-driven and directed
// sequences with hand-computed tap values.
module tb_dilated_tap_buffer;

    localparam int W        = 16;
    localparam int C        = 4;
    localparam int DILATION = 4;
    localparam int DEPTH    = 3 * DILATION + 1;

    logic                clk;
    logic                rst;
    logic                inp_v;
    logic signed [W-1:0] inp [0:C-1];
    logic signed [W-1:0] a0  [0:C-1];
    logic signed [W-1:0] a1  [0:C-1];
    logic signed [W-1:0] a2  [0:C-1];
    logic signed [W-1:0] a3  [0:C-1];
    logic                out_v;
    logic                primed;

    dilated_tap_buffer #(.W(W), .C(C), .DILATION(DILATION)) dut (
        .clk    (clk),
        .rst    (rst),
        .inp    (inp),
        .inp_v  (inp_v),
        .a0     (a0),
        .a1     (a1),
        .a2     (a2),
        .a3     (a3),
        .out_v  (out_v),
        .primed (primed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int drv_n    = 0;
    bit mon_en   = 1'b0;

    // Expected taps as sample numbers (0 = empty history slot).
    typedef struct {
        int t3;
        int t2;
        int t1;
        int t0;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_exp;
    int   hist[$];
    int   wr_cnt = 0;

    typedef struct {
        int n;
        int e3;
        int e2;
        int e1;
        int e0;
        bit ep;
    } vec_t;

    vec_t tbl[13];

    function automatic int ev(input int n, input int c);
        return (n == 0) ? 0 : (100 * c + n);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic compare_taps(input string tag, input int e3, input int e2,
                                input int e1, input int e0);
        for (int c = 0; c < C; c++) begin
            check($sformatf("%s a3[%0d]", tag, c), int'(a3[c]), ev(e3, c));
            check($sformatf("%s a2[%0d]", tag, c), int'(a2[c]), ev(e2, c));
            check($sformatf("%s a1[%0d]", tag, c), int'(a1[c]), ev(e1, c));
            check($sformatf("%s a0[%0d]", tag, c), int'(a0[c]), ev(e0, c));
        end
    endtask

    // Reference model: tracks written sample numbers since reset.
    always @(posedge clk) begin
        if (rst) begin
            hist.delete();
            exp_q.delete();
            wr_cnt   = 0;
            last_exp = '{t3: 0, t2: 0, t1: 0, t0: 0};
        end else if (inp_v) begin
            exp_t e;
            int   k;
            hist.push_back(drv_n);
            k    = hist.size() - 1;
            e.t3 = hist[k];
            e.t2 = (k >= DILATION)     ? hist[k - DILATION]     : 0;
            e.t1 = (k >= 2 * DILATION) ? hist[k - 2 * DILATION] : 0;
            e.t0 = (k >= 3 * DILATION) ? hist[k - 3 * DILATION] : 0;
            exp_q.push_back(e);
            if (wr_cnt < DEPTH) wr_cnt++;
        end
    end

    // Scoreboard: every cycle checks strobe, taps (new or held) and primed.
    always @(negedge clk) begin
        if (mon_en) begin
            check("sb out_v", int'(out_v), int'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                last_exp = exp_q.pop_front();
            end
            compare_taps("sb", last_exp.t3, last_exp.t2, last_exp.t1, last_exp.t0);
            check("sb primed", int'(primed), int'(wr_cnt >= DEPTH));
        end
    end

    task automatic set_inp(input int n);
        drv_n = n;
        for (int c = 0; c < C; c++) begin
            inp[c] = W'(100 * c + n);
        end
    endtask

    task automatic do_write(input int n);
        inp_v = 1'b1;
        set_inp(n);
        @(posedge clk);
        #1;
        inp_v = 1'b0;
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        inp_v = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{n: 1,  e3: 1,  e2: 0, e1: 0, e0: 0, ep: 1'b0};
        tbl[1]  = '{n: 2,  e3: 2,  e2: 0, e1: 0, e0: 0, ep: 1'b0};
        tbl[2]  = '{n: 3,  e3: 3,  e2: 0, e1: 0, e0: 0, ep: 1'b0};
        tbl[3]  = '{n: 4,  e3: 4,  e2: 0, e1: 0, e0: 0, ep: 1'b0};
        tbl[4]  = '{n: 5,  e3: 5,  e2: 1, e1: 0, e0: 0, ep: 1'b0};
        tbl[5]  = '{n: 6,  e3: 6,  e2: 2, e1: 0, e0: 0, ep: 1'b0};
        tbl[6]  = '{n: 7,  e3: 7,  e2: 3, e1: 0, e0: 0, ep: 1'b0};
        tbl[7]  = '{n: 8,  e3: 8,  e2: 4, e1: 0, e0: 0, ep: 1'b0};
        tbl[8]  = '{n: 9,  e3: 9,  e2: 5, e1: 1, e0: 0, ep: 1'b0};
        tbl[9]  = '{n: 10, e3: 10, e2: 6, e1: 2, e0: 0, ep: 1'b0};
        tbl[10] = '{n: 11, e3: 11, e2: 7, e1: 3, e0: 0, ep: 1'b0};
        tbl[11] = '{n: 12, e3: 12, e2: 8, e1: 4, e0: 0, ep: 1'b0};
        tbl[12] = '{n: 13, e3: 13, e2: 9, e1: 5, e0: 1, ep: 1'b1};

        rst   = 1'b1;
        inp_v = 1'b0;
        set_inp(0);
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        idle(2);
        rst = 1'b0;

        // Reset then idle: everything stays zero.
        for (int i = 0; i < 5; i++) begin
            idle(1);
            check("idle out_v", int'(out_v), 0);
            check("idle primed", int'(primed), 0);
            compare_taps("idle", 0, 0, 0, 0);
        end

        // Single write of sample 5, one-cycle strobe.
        do_write(5);
        check("single out_v", int'(out_v), 1);
        check("single primed", int'(primed), 0);
        compare_taps("single", 5, 0, 0, 0);
        idle(1);
        check("single out_v drop", int'(out_v), 0);
        compare_taps("single hold", 5, 0, 0, 0);

        // Back-to-back table: 13 writes, priming on the last.
        do_reset();
        for (int i = 0; i < 13; i++) begin
            inp_v = 1'b1;
            set_inp(tbl[i].n);
            @(posedge clk);
            #1;
            check($sformatf("b2b[%0d] out_v", i), int'(out_v), 1);
            check($sformatf("b2b[%0d] primed", i), int'(primed), int'(tbl[i].ep));
            compare_taps($sformatf("b2b[%0d]", i), tbl[i].e3, tbl[i].e2, tbl[i].e1, tbl[i].e0);
        end
        inp_v = 1'b0;
        check("b2b a0[3]", int'(a0[3]), 301);
        idle(2);
        check("b2b primed hold", int'(primed), 1);

        // 20 writes with random idle gaps: wrap of the circular buffer.
        do_reset();
        for (int n = 1; n <= 20; n++) begin
            do_write(n);
            idle(int'($urandom_range(0, 3)));
        end
        check("gap a3[1]", int'(a3[1]), 120);
        check("gap a2[1]", int'(a2[1]), 116);
        check("gap a1[1]", int'(a1[1]), 112);
        check("gap a0[1]", int'(a0[1]), 108);
        check("gap primed", int'(primed), 1);

        // Reset mid-stream discards history.
        do_reset();
        for (int n = 1; n <= 7; n++) do_write(n);
        do_reset();
        check("midrst primed", int'(primed), 0);
        check("midrst out_v", int'(out_v), 0);
        do_write(42);
        compare_taps("midrst", 42, 0, 0, 0);
        check("midrst primed after", int'(primed), 0);

        // Reset and write on the same edge: sample is dropped.
        do_write(9);
        rst   = 1'b1;
        inp_v = 1'b1;
        set_inp(77);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        inp_v = 1'b0;
        check("rstwr out_v", int'(out_v), 0);
        compare_taps("rstwr idle", 0, 0, 0, 0);
        do_write(3);
        check("rstwr a3[0]", int'(a3[0]), 3);
        check("rstwr a2[0]", int'(a2[0]), 0);
        check("rstwr a1[0]", int'(a1[0]), 0);
        check("rstwr a0[0]", int'(a0[0]), 0);
        for (int n = 4; n <= 7; n++) do_write(n);
        check("rstwr a2[0] after", int'(a2[0]), 3);
        idle(2);

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dilated_tap_buffer.md
Name: dilated_tap_buffer

Overview:
- Per-channel history buffer between a conv1d layer's activation outputs and the next dilated conv1d layer.
- Accepts one C-channel activation vector per inp_v strobe and stores it in a circular buffer.
- Presents K taps spaced DILATION samples apart as a0..a3, directly wireable to the next conv1d's a0..a3 inputs.
- Replaces per-channel activation_cache instances plus ad-hoc glue for layers with dilation > 1.

Parameters:
W, 16, signed element width
C, 4, channels per activation vector
DILATION, 4, sample spacing between adjacent taps; legal range 1..8
DEPTH (localparam), 3*DILATION+1, buffer entries per channel (13 at default)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
inp  input  signed [W-1:0] x [0:C-1]  activation vector from upstream conv1d out
inp_v  input  1  write strobe; inp sampled on a clk edge where inp_v=1
a0  output  signed [W-1:0] x [0:C-1]  tap x[t-3*DILATION] (oldest)
a1  output  signed [W-1:0] x [0:C-1]  tap x[t-2*DILATION]
a2  output  signed [W-1:0] x [0:C-1]  tap x[t-DILATION]
a3  output  signed [W-1:0] x [0:C-1]  tap x[t] (newest)
out_v  output  1  one-cycle pulse: a0..a3 updated
primed  output  1  high once DEPTH samples written since reset

Behaviour:
- Clock and reset: one clock (clk); rst is synchronous, active-high.
- Reset state: all DEPTH*C storage entries 0; write pointer wp=0; fill counter=0; a0..a3 all elements 0; out_v=0; primed=0.
- rst priority: rst=1 with inp_v=1 on the same edge means rst wins and the sample is dropped.
- Write (edge with inp_v=1, rst=0):
  - mem[wp] <= inp for all C channels.
  - wp <= (wp==DEPTH-1) ? 0 : wp+1.
  - Fill counter increments, saturating at DEPTH.
- Taps are registered and updated on the same edge as the write, computed against the post-write contents. With n = index of the just-written entry:
  - a3 = inp (bypass; do not read stale memory).
  - a2 = mem[(n-DILATION) mod DEPTH].
  - a1 = mem[(n-2*DILATION) mod DEPTH].
  - a0 = mem[(n-3*DILATION) mod DEPTH].
  - Modulo is a true wrap into 0..DEPTH-1, with no out-of-range index at any wp.
- Latency: inp_v at edge n gives taps valid and out_v=1 in the cycle after edge n. Zero bubbles.
- out_v: 1 for exactly the cycle following each accepted write, else 0. Back-to-back inp_v every cycle gives out_v high every cycle.
- No write (inp_v=0): a0..a3, wp, and storage hold; out_v=0.
- Before primed: taps older than the written history read 0 because storage was cleared at reset.
- primed: goes 1 in the same cycle as out_v for the DEPTH-th write; stays 1 until rst.
- Arithmetic: pure storage, no arithmetic. Values pass bit-exact, with no saturation or sign change.
- Reset mid-stream: all history discarded. The first post-reset write behaves exactly as the first write after power-up.
- Channels are independent: channel c taps only ever contain channel c data.
- Implementation freedom: registers or inferred RAM are both acceptable. The tap read path must meet the stated one-cycle latency.

Test Plan (defaults W=16, C=4, DILATION=4, DEPTH=13; sample n carries channel c value 100*c+n):
- Reset then idle 5 cycles -> all taps 0, out_v=0, primed=0 throughout.
- One write, n=5 -> next cycle out_v=1 for exactly one cycle; a3={5,105,205,305}; a2, a1, a0 all 0; primed=0.
- 13 back-to-back writes, n=1..13 -> out_v high 13 consecutive cycles; after the last write a3[0]=13, a2[0]=9, a1[0]=5, a0[0]=1, a0[3]=301; primed rises with the 13th out_v.
- 20 writes with random 0-3 idle gaps, n=1..20 -> after the last write a3[1]=120, a2[1]=116, a1[1]=112, a0[1]=108 (wrap exercised); during gaps taps hold and out_v=0.
- 7 writes, then rst, then one write of n=42 -> a3[0]=42; a2, a1, a0 all 0; primed=0.
- rst=1 and inp_v=1 on the same edge, then one write of n=3 -> dropped sample absent; a3[0]=3; a2[0]=0; a1[0]=0; a0[0]=0.
